// File: rtl/phase_sequencer.sv
// Phase sequencer: steps through up to four timed phases, arming an external
// chronometer for each one and waiting on its sticky finished flag.
module phase_sequencer #(
  parameter int          NUM_PHASES = 4,
  parameter logic [15:0] T0         = 16'd2,
  parameter logic [15:0] T1         = 16'd5,
  parameter logic [15:0] T2         = 16'd3,
  parameter logic [15:0] T3         = 16'd1
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  timer_finished,
  output logic                  timer_reset,
  output logic [15:0]           seconds_to_count,
  output logic [1:0]            phase,
  output logic [NUM_PHASES-1:0] phase_active,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [1:0] LAST_PHASE = 2'(NUM_PHASES - 1);

  state_t      state;
  logic [1:0]  entry_phase;
  logic [15:0] entry_secs;

  function automatic logic [15:0] duration(input logic [1:0] p);
    case (p)
      2'd0:    return T0;
      2'd1:    return T1;
      2'd2:    return T2;
      default: return T3;
    endcase
  endfunction

  // Phase about to be loaded: 0 when leaving IDLE, otherwise the successor.
  // NOTE: every always_comb output gets a value on every path so no latch is inferred.
  always_comb begin
    entry_phase = 2'd0;
    if (state != S_IDLE) entry_phase = phase + 2'd1;
    entry_secs = duration(entry_phase);
  end

  // Outputs are computed for the state being entered so they are all registered;
  // timer_reset is therefore already high during the LOAD cycle itself.
  // NOTE: all state and outputs use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state            <= S_IDLE;
      phase            <= 2'd0;
      seconds_to_count <= 16'd0;
      timer_reset      <= 1'b0;
      phase_active     <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      timer_reset <= 1'b0;
      done        <= 1'b0;
      if (state != S_IDLE && abort) begin
        state        <= S_IDLE;
        timer_reset  <= 1'b1;
        phase_active <= '0;
        busy         <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state            <= S_LOAD;
              phase            <= entry_phase;
              seconds_to_count <= entry_secs;
              timer_reset      <= (entry_secs != 16'd0);
              busy             <= 1'b1;
            end
          end
          S_LOAD: begin
            if (seconds_to_count == 16'd0) begin
              state <= S_NEXT;
            end else begin
              state        <= S_ARM;
              phase_active <= NUM_PHASES'(1) << phase;
            end
          end
          // The finished flag may still be stale here, so it is not looked at.
          S_ARM: state <= S_WAIT;
          S_WAIT: begin
            if (timer_finished) begin
              state        <= S_NEXT;
              phase_active <= '0;
            end
          end
          S_NEXT: begin
            if (phase == LAST_PHASE) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state            <= S_LOAD;
              phase            <= entry_phase;
              seconds_to_count <= entry_secs;
              timer_reset      <= (entry_secs != 16'd0);
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: two instances (default durations, and phase 1 of
// zero length), each driven by a chronometer model and checked every cycle.
`timescale 1ns/1ps
module tb_phase_sequencer;

  // Chronometer clocks per "second"; keeps the runs short while the sequencer
  // logic is independent of the real 10 kHz scale.
  localparam int S = 4;

  localparam int K_LOAD = 0;
  localparam int K_ARM  = 1;
  localparam int K_WAIT = 2;
  localparam int K_NEXT = 3;
  localparam int K_DONE = 4;

  typedef struct {
    int kind;
    int ph;
  } step_t;

  logic CLK   = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait budget expired, expected event not seen", name);
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam logic [15:0] T1_VAL = (g == 0) ? 16'd5 : 16'd0;
    localparam logic [15:0] TT [4] = '{16'd2, T1_VAL, 16'd3, 16'd1};

    logic        tr, busy, done;
    logic [15:0] secs;
    logic [1:0]  ph;
    logic [3:0]  act;
    logic        fin   = 1'b0;
    logic        fin_d = 1'b0;
    int          cnt   = 0;
    int          cyc = 0, tr_cnt = 0, done_cnt = 0, done_cyc = 0;

    phase_sequencer #(
      .NUM_PHASES(4),
      .T1        (T1_VAL)
    ) dut (
      .CLK             (CLK),
      .reset           (reset),
      .start           (start),
      .abort           (abort),
      .timer_finished  (fin_d),
      .timer_reset     (tr),
      .seconds_to_count(secs),
      .phase           (ph),
      .phase_active    (act),
      .busy            (busy),
      .done            (done)
    );

    // Chronometer: counts secs*S clocks after a reset pulse, then raises a sticky
    // flag; the flag is seen one clock late so it is still stale during ARM.
    always @(posedge CLK) begin
      if (tr) begin
        cnt <= int'(secs) * S;
        fin <= 1'b0;
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) fin <= 1'b1;
      end
      fin_d <= fin;
    end

    // Reference: a start expands the whole sequence into a script of steps;
    // each clock consumes one step, except a WAIT step that holds until finished.
    initial begin : model
      step_t       sched[$];
      step_t       cur;
      bit          idle, ab, valid;
      logic [1:0]  m_phase;
      logic [15:0] m_secs;
      logic        c_rst, c_start, c_abort, c_fin;
      logic        exp_tr, exp_busy, exp_done;
      logic [3:0]  exp_act;
      idle = 1'b1; ab = 1'b0; valid = 1'b0; m_phase = 2'd0; m_secs = 16'd0;
      cur = step_t'{K_DONE, 3};
      forever begin
        @(posedge CLK);
        c_rst = reset; c_start = start; c_abort = abort; c_fin = fin_d;
        @(negedge CLK);
        ab = 1'b0;
        if (c_rst) begin
          idle = 1'b1; m_phase = 2'd0; m_secs = 16'd0; valid = 1'b1;
          sched.delete();
        end else if (idle) begin
          if (c_start) begin
            sched.delete();
            for (int p = 0; p < 4; p++) begin
              sched.push_back(step_t'{K_LOAD, p});
              if (TT[p] != 16'd0) begin
                sched.push_back(step_t'{K_ARM, p});
                sched.push_back(step_t'{K_WAIT, p});
              end
              sched.push_back(step_t'{K_NEXT, p});
            end
            sched.push_back(step_t'{K_DONE, 3});
            idle = 1'b0;
            cur = sched.pop_front();
            m_phase = 2'(cur.ph);
            m_secs = TT[cur.ph];
          end
        end else if (c_abort) begin
          idle = 1'b1; ab = 1'b1;
          sched.delete();
        end else if (cur.kind == K_WAIT && !c_fin) begin
          idle = 1'b0;
        end else if (sched.size() == 0) begin
          idle = 1'b1;
        end else begin
          cur = sched.pop_front();
          m_phase = 2'(cur.ph);
          if (cur.kind == K_LOAD) m_secs = TT[cur.ph];
        end

        exp_tr   = idle ? ab : (cur.kind == K_LOAD && TT[cur.ph] != 16'd0);
        exp_act  = (!idle && (cur.kind == K_ARM || cur.kind == K_WAIT)) ? (4'b0001 << cur.ph) : 4'b0000;
        exp_busy = !idle;
        exp_done = !idle && cur.kind == K_DONE;

        cyc++;
        if (tr === 1'b1) tr_cnt++;
        if (done === 1'b1) begin
          done_cnt++;
          done_cyc = cyc;
        end

        if (valid) begin
          check($sformatf("i%0d timer_reset cyc %0d", g, cyc), 32'(tr), 32'(exp_tr));
          check($sformatf("i%0d seconds_to_count cyc %0d", g, cyc), 32'(secs), 32'(m_secs));
          check($sformatf("i%0d phase cyc %0d", g, cyc), 32'(ph), 32'(m_phase));
          check($sformatf("i%0d phase_active cyc %0d", g, cyc), 32'(act), 32'(exp_act));
          check($sformatf("i%0d busy cyc %0d", g, cyc), 32'(busy), 32'(exp_busy));
          check($sformatf("i%0d done cyc %0d", g, cyc), 32'(done), 32'(exp_done));
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((gi[0].busy || gi[1].busy) && n < 600) begin
      tick(1);
      n++;
    end
    if (n >= 600) timeout_fail("wait for idle");
  endtask

  // Leaves instance 0 in the first WAIT cycle of phase p.
  task automatic wait_in_wait(input int p);
    int n = 0;
    while (!gi[0].act[p] && n < 400) begin
      tick(1);
      n++;
    end
    if (n >= 400) timeout_fail($sformatf("wait for phase %0d", p));
    else tick(1);
  endtask

  task automatic run_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin : stim
    int tr0, tr1, dn0, dn1, tr_cyc, n;

    reset = 1'b1;
    tick(2);
    check("reset timer_reset", 32'(gi[0].tr), 32'd0);
    check("reset seconds", 32'(gi[0].secs), 32'd0);
    check("reset phase", 32'(gi[0].ph), 32'd0);
    check("reset phase_active", 32'(gi[0].act), 32'd0);
    check("reset busy", 32'(gi[0].busy), 32'd0);
    check("reset done", 32'(gi[0].done), 32'd0);
    reset = 1'b0;
    tick(2);

    // Nominal run on both instances
    tr0 = gi[0].tr_cnt; tr1 = gi[1].tr_cnt; dn0 = gi[0].done_cnt; dn1 = gi[1].done_cnt;
    run_start();
    check("first timer_reset", 32'(gi[0].tr), 32'd1);
    check("first seconds", 32'(gi[0].secs), 32'd2);
    check("first busy", 32'(gi[0].busy), 32'd1);
    tr_cyc = gi[0].cyc;
    tick(1);
    check("phase_active at k+2", 32'(gi[0].act), 32'b0001);
    wait_idle();
    check("nominal timer_reset pulses", 32'(gi[0].tr_cnt - tr0), 32'd4);
    check("skip timer_reset pulses", 32'(gi[1].tr_cnt - tr1), 32'd3);
    check("nominal done pulses", 32'(gi[0].done_cnt - dn0), 32'd1);
    check("skip done pulses", 32'(gi[1].done_cnt - dn1), 32'd1);
    check("nominal run length", 32'(gi[0].done_cyc - tr_cyc), 32'd60);
    check("skip run length", 32'(gi[1].done_cyc - tr_cyc), 32'd38);
    tick(3);

    // start pulsed while busy is ignored
    tr0 = gi[0].tr_cnt; dn0 = gi[0].done_cnt;
    run_start();
    wait_in_wait(1);
    run_start();
    check("start while busy phase", 32'(gi[0].ph), 32'd1);
    wait_idle();
    check("start while busy pulses", 32'(gi[0].tr_cnt - tr0), 32'd4);
    check("start while busy done", 32'(gi[0].done_cnt - dn0), 32'd1);
    tick(2);

    // Abort during WAIT of phase 2, then restart
    dn0 = gi[0].done_cnt;
    run_start();
    wait_in_wait(2);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort timer_reset", 32'(gi[0].tr), 32'd1);
    check("abort busy", 32'(gi[0].busy), 32'd0);
    check("abort phase_active", 32'(gi[0].act), 32'd0);
    check("abort done", 32'(gi[0].done), 32'd0);
    check("abort phase held", 32'(gi[0].ph), 32'd2);
    tick(1);
    check("abort pulse width", 32'(gi[0].tr), 32'd0);
    wait_idle();
    check("abort no done", 32'(gi[0].done_cnt - dn0), 32'd0);
    run_start();
    check("restart phase", 32'(gi[0].ph), 32'd0);
    check("restart timer_reset", 32'(gi[0].tr), 32'd1);
    wait_idle();
    tick(2);

    // Synchronous reset mid-WAIT
    run_start();
    wait_in_wait(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("mid reset phase", 32'(gi[0].ph), 32'd0);
    check("mid reset seconds", 32'(gi[0].secs), 32'd0);
    check("mid reset busy", 32'(gi[0].busy), 32'd0);
    check("mid reset phase_active", 32'(gi[0].act), 32'd0);
    tr0 = gi[0].tr_cnt; dn0 = gi[0].done_cnt;
    tick(1);
    run_start();
    wait_idle();
    check("post reset pulses", 32'(gi[0].tr_cnt - tr0), 32'd4);
    check("post reset done", 32'(gi[0].done_cnt - dn0), 32'd1);

    // start held through DONE restarts on the first IDLE cycle
    start = 1'b1;
    n = 0;
    while (!gi[0].done && n < 400) begin
      tick(1);
      n++;
    end
    if (n >= 400) timeout_fail("wait for done");
    tick(1);
    check("held start idle busy", 32'(gi[0].busy), 32'd0);
    tick(1);
    check("held start restart", 32'(gi[0].tr), 32'd1);
    start = 1'b0;
    wait_idle();

    // Randomized traffic with occasional abort, reset and stray starts
    for (int it = 0; it < 20; it++) begin
      tick($urandom_range(0, 5));
      start = 1'b1;
      tick($urandom_range(1, 3));
      start = 1'b0;
      for (int c = 0; c < 300 && (gi[0].busy || gi[1].busy); c++) begin
        abort = ($urandom_range(0, 59) == 0);
        reset = ($urandom_range(0, 149) == 0);
        start = ($urandom_range(0, 19) == 0);
        tick(1);
      end
      abort = 1'b0;
      reset = 1'b0;
      start = 1'b0;
      wait_idle();
    end

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
